imem_boot_loader: RTL

Upstream neighbour of the single-cycle CPU. It receives a program image as a byte stream over a valid/ready handshake and packs the bytes into 32-bit little-endian instruction words. It writes those words into the instruction memory's write port and holds the CPU in reset until the image is fully and correctly loaded. After a successful load it releases the CPU, which then fetches from byte address 0.

---
 rtl/imem_boot_loader_pkg.sv | 23 ++
 rtl/imem_boot_loader_if.sv | 20 ++
 rtl/imem_boot_loader_byte_packer.sv | 50 +++++
 rtl/imem_boot_loader.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// The optional checksum check is enabled by defining BOOT_CHECKSUM_EN.
package boot_pkg;

    typedef enum logic [2:0] {
        WAIT_LEN = 3'd0,
        LOAD     = 3'd1,
        CHECK    = 3'd2,
        DONE     = 3'd3,
        ERROR    = 3'd4
    } boot_state_t;

    localparam int LEN_BYTES         = 2;
    localparam int BYTES_PER_WORD    = 4;
    localparam int DEFAULT_ADDR_W    = 10;
    localparam int DEFAULT_MAX_WORDS = 1024;

    // The instruction memory is addressed in bytes, so a word index becomes 4*index.
    function automatic logic [31:0] word_byte_addr(input logic [29:0] idx);
        return {idx, 2'b00};
    endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The loader itself connects through the slave modport.
interface imem_boot_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_boot_loader_byte_packer.sv
// Assembles little-endian bytes into 32-bit words; the finished word is held in its
// own register so the next word can start filling during the write cycle.
module byte_packer
    import boot_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        byte_last,
    output logic        word_valid,
    output logic [31:0] word
);

    localparam int CNT_W = $clog2(BYTES_PER_WORD);
    localparam int PART_W = 8 * (BYTES_PER_WORD - 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES_PER_WORD - 1);

    logic [CNT_W-1:0]  byte_cnt;
    logic [PART_W-1:0] partial;

    assign byte_last = in_valid && (byte_cnt == LAST);

    // New bytes enter at the top and shift down, so the first byte ends up in [7:0].
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt   <= '0;
            partial    <= '0;
            word_valid <= 1'b0;
            word       <= '0;
        end else if (clear) begin
            byte_cnt   <= '0;
            partial    <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= byte_last;
            if (in_valid) begin
                if (byte_last) begin
                    word     <= {in_byte, partial};
                    byte_cnt <= '0;
                end else begin
                    partial  <= {in_byte, partial[PART_W-1:8]};
                    byte_cnt <= byte_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed byte image, writes it into instruction memory
// and holds the CPU in reset until done. Define BOOT_CHECKSUM_EN for a trailing XOR check.
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int ADDR_W    = DEFAULT_ADDR_W,
    parameter int MAX_WORDS = DEFAULT_MAX_WORDS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                restart,
    imem_boot_loader_if.slave   bus,
    output logic                cpu_rst,
    output logic                load_done,
    output logic                load_err
);

    localparam int LEN_IDX_W = $clog2(LEN_BYTES);
    localparam logic [LEN_IDX_W-1:0] LEN_LAST = LEN_IDX_W'(LEN_BYTES - 1);
    localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

    boot_state_t state, state_next;

    logic                 armed;
    logic [LEN_IDX_W-1:0] len_idx;
    logic [7:0]           len_lo;
    logic [ADDR_W:0]      n_words;
    logic [ADDR_W:0]      words_packed;
    logic [ADDR_W:0]      word_idx;
    logic [15:0]          len_value;
    logic                 len_bad;
    logic                 rx_ready;
    logic                 accept;
    logic                 pack_valid;
    logic                 byte_last;
    logic                 word_valid;
    logic [31:0]          word;
    logic                 we;
    logic                 last_write;
    logic                 restart_clear;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]           csum;
`endif

    assign len_value     = {bus.rx_data, len_lo};
    assign len_bad       = (len_value == 16'd0) || (32'(len_value) > MAX_WORDS);
    assign accept        = bus.rx_valid && rx_ready;
    assign pack_valid    = accept && (state == LOAD);
    assign we            = word_valid && (state == LOAD);
    assign last_write    = we && ((word_idx + ONE) == n_words);
    assign restart_clear = restart && ((state == DONE) || (state == ERROR));

    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (restart_clear),
        .in_valid   (pack_valid),
        .in_byte    (bus.rx_data),
        .byte_last  (byte_last),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= WAIT_LEN;
        else       state <= state_next;
    end

    // LOAD stops accepting once every payload byte is in, so a trailing checksum
    // byte is not swallowed during the final write cycle.
    always_comb begin
        state_next = state;
        rx_ready   = 1'b0;
        case (state)
            WAIT_LEN: begin
                rx_ready = armed;
                if (accept && (len_idx == LEN_LAST))
                    state_next = len_bad ? ERROR : LOAD;
            end
            LOAD: begin
                rx_ready = (words_packed != n_words);
`ifdef BOOT_CHECKSUM_EN
                if (last_write) state_next = CHECK;
`else
                if (last_write) state_next = DONE;
`endif
            end
`ifdef BOOT_CHECKSUM_EN
            CHECK: begin
                rx_ready = 1'b1;
                if (bus.rx_valid)
                    state_next = (bus.rx_data == csum) ? DONE : ERROR;
            end
`endif
            DONE, ERROR: begin
                if (restart) state_next = WAIT_LEN;
            end
            default: state_next = WAIT_LEN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            armed        <= 1'b0;
            len_idx      <= '0;
            len_lo       <= '0;
            n_words      <= '0;
            words_packed <= '0;
            word_idx     <= '0;
`ifdef BOOT_CHECKSUM_EN
            csum         <= '0;
`endif
        end else begin
            armed <= 1'b1;
            if (restart_clear) begin
                len_idx      <= '0;
                len_lo       <= '0;
                n_words      <= '0;
                words_packed <= '0;
                word_idx     <= '0;
`ifdef BOOT_CHECKSUM_EN
                csum         <= '0;
`endif
            end else begin
                if ((state == WAIT_LEN) && accept) begin
                    len_lo <= bus.rx_data;
                    if (len_idx == LEN_LAST) begin
                        len_idx <= '0;
                        n_words <= len_value[ADDR_W:0];
                    end else begin
                        len_idx <= len_idx + 1'b1;
                    end
                end
                if (pack_valid && byte_last) words_packed <= words_packed + ONE;
                if (we) word_idx <= word_idx + ONE;
`ifdef BOOT_CHECKSUM_EN
                if (pack_valid) csum <= csum ^ bus.rx_data;
`endif
            end
        end
    end

    assign bus.rx_ready   = rx_ready;
    assign bus.imem_we    = we;
    assign bus.imem_addr  = word_byte_addr(30'(word_idx));
    assign bus.imem_wdata = word;

    assign cpu_rst   = (state != DONE);
    assign load_done = (state == DONE);
    assign load_err  = (state == ERROR);

endmodule
